urv_regfile_mp: RTL and testbench
=================================

// Module: urv_regfile_mp
// PURPOSE
//  Parametrised N-read/1-write integer register file for the uRV decode->execute boundary.
//  - One replicated 1R1W bank per read port; reads are registered.
//  - Execute-stage (X) and writeback-stage (W) bypass on every read port.
//  - Built-in post-reset clear sequencer, so the banks need no reset and map to block/distributed RAM.
//  - Stall-coherent: a write that hits a held read address while stalled is not lost.
// PARAMETERS
//  XLEN        32  data width of each register
//  NREGS       32  number of architectural registers (power of 2, >=2); AW = clog2(NREGS)
//  NRD          2  number of read ports (1..4)
//  ZERO_REG     1  1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary
//  INIT_CLEAR   1  1: after reset, write 0 to every entry before accepting traffic
// PORTS
//  clk_i                in   1         single clock, rising edge
//  rst_i                in   1         synchronous reset, active-high
//  d_stall_i            in   1         decode stall; holds read outputs and bypass state
//  rf_rs_i              in   NRD*AW    read addresses presented to banks (port k = slice k)
//  d_rs_i               in   NRD*AW    decode-stage source addresses for X-bypass compare
//  x_rs_value_o         out  NRD*XLEN  operand values to execute stage
//  w_rd_i               in   AW        writeback destination address
//  w_rd_value_i         in   XLEN      writeback data
//  w_rd_store_i         in   1         writeback write strobe
//  w_bypass_rd_write_i  in   1         X-stage result valid for bypass
//  w_bypass_rd_value_i  in   XLEN      X-stage result value
//  init_busy_o          out  1         clear sequence in progress; core must stall
// BEHAVIOUR
//  - Reset (rst_i=1 at a clock edge):
//    - all read registers, W-bypass flags and W-bypass values := 0;
//    - FSM := CLEAR (INIT_CLEAR=1) or RUN (INIT_CLEAR=0);
//    - init_busy_o = 1 in CLEAR, 0 in RUN.
//    Reset asserted mid-CLEAR restarts the counter at 0.
//  - FSM CLEAR:
//    - clr_cnt 0..NREGS-1, one entry per cycle; every bank writes 0 at clr_cnt;
//    - clr_cnt==NREGS-1 -> RUN next cycle, so CLEAR lasts exactly NREGS cycles;
//    - pipeline writes are dropped; read registers do not update.
//    RUN is absorbing until the next reset.
//  - Write, RUN only: we = w_rd_store_i && !(ZERO_REG && w_rd_i==0); all banks are written identically.
//  - Read port k, latency 1:
//    - if !d_stall_i && RUN, q[k] <= bank_k[rf_rs_i[k]];
//    - forced 0 when ZERO_REG && rf_rs_i[k]==0.
//    - A read and a write to the same address in the same cycle return the OLD array data; W-bypass corrects it.
//  - W-bypass, per port k, registered:
//    - !d_stall_i: wb_hit[k] <= we && rf_rs_i[k]==w_rd_i; on hit, wb_val[k] <= w_rd_value_i.
//    - d_stall_i: if we && w_rd_i == rf_rs_q[k] (the latched address), wb_hit[k] <= 1 and wb_val[k] <= w_rd_value_i; otherwise hold.
//  - X-bypass, combinational:
//    - xb[k] = w_bypass_rd_write_i && w_rd_i==d_rs_i[k] && !(ZERO_REG && w_rd_i==0).
//  - Output mux priority per port: xb[k] -> w_bypass_rd_value_i; else wb_hit[k] -> wb_val[k]; else q[k].
//  - Back-to-back writes to one address: the last write wins in the array and in wb_val.
//  - All outputs read 0 from reset until the first RUN read.
// STRUCTURE
//  - Package urv_regfile_pkg:
//    - clog2 function;
//    - state enum {RF_CLEAR, RF_RUN};
//    - default XLEN/NREGS constants.
//  - Sub-module urv_regmem_1r1w #(XLEN,NREGS):
//    - async-read or sync-read array, write port (we,wa,wd), no reset;
//    - instantiated NRD times in a generate loop.
//  - Top level holds the FSM, clear counter, per-port q/rf_rs_q/wb_hit/wb_val and the bypass muxes.
// TESTING
//  - Reset then idle, NREGS=32:
//    - init_busy_o=1 for exactly 32 cycles then 0;
//    - read every register -> 0 on all ports;
//    - a write issued during CLEAR is dropped (subsequent read = 0).
//  - Write x5=0xDEADBEEF, next cycle read x5 on ports 0,1 -> both 0xDEADBEEF one cycle after address.
//  - Same cycle: write x7=0x11, rf_rs_i[0]=7 -> port 0 = 0x11 (W-bypass);
//    - also d_rs_i[1]=7 with w_bypass value 0x22 -> port 1 = 0x22 (X priority).
//  - Write x0=0xFFFFFFFF, ZERO_REG=1: read x0 -> 0; X-bypass on rd=0 not taken.
//    - With ZERO_REG=0 the read returns 0xFFFFFFFF.
//  - Latch rf_rs_i[0]=9, hold d_stall_i=1, write x9=0xA5A5A5A5 during stall -> output 0xA5A5A5A5 while still stalled and after release.
//  - Assert rst_i at clr_cnt=10 -> counter restarts; init_busy_o high a further 32 cycles.

Source files
------------

// File: rtl/urv_regfile_mp_pkg.sv
// Shared types and constants for the uRV multi-port register file.
package urv_regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   typedef enum logic {RF_CLEAR, RF_RUN} rf_state_e;

   // Ceiling log2, minimum 1 so a 2-entry file still gets an address bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/urv_regfile_mp_if.sv
// Decode/execute/writeback-facing signal bundle of the register file.
interface urv_regfile_mp_if
   import urv_regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2
);
   localparam int AW = clog2(NREGS);

   logic                           d_stall_i;
   logic [NRD-1:0][AW-1:0]         rf_rs_i;
   logic [NRD-1:0][AW-1:0]         d_rs_i;
   logic [NRD-1:0][XLEN-1:0]       x_rs_value_o;
   logic [AW-1:0]                  w_rd_i;
   logic [XLEN-1:0]                w_rd_value_i;
   logic                           w_rd_store_i;
   logic                           w_bypass_rd_write_i;
   logic [XLEN-1:0]                w_bypass_rd_value_i;
   logic                           init_busy_o;

   modport master (
      output d_stall_i, rf_rs_i, d_rs_i, w_rd_i, w_rd_value_i, w_rd_store_i,
             w_bypass_rd_write_i, w_bypass_rd_value_i,
      input  x_rs_value_o, init_busy_o
   );

   modport slave (
      input  d_stall_i, rf_rs_i, d_rs_i, w_rd_i, w_rd_value_i, w_rd_store_i,
             w_bypass_rd_write_i, w_bypass_rd_value_i,
      output x_rs_value_o, init_busy_o
   );

endinterface

// File: rtl/urv_regmem_1r1w.sv
// One 1R1W register bank: async read, single write port, no reset so it
// can map onto distributed RAM.
module urv_regmem_1r1w
   import urv_regfile_pkg::*;
#(
   parameter  int XLEN  = XLEN_DEF,
   parameter  int NREGS = NREGS_DEF,
   localparam int AW    = clog2(NREGS)
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   input  logic [AW-1:0]   ra,
   output logic [XLEN-1:0] rd
);

   logic [XLEN-1:0] mem [NREGS];

   // Array write; contents only defined after the top-level clear sweep.
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   assign rd = mem[ra];

endmodule

// File: rtl/urv_regfile_mp.sv
// N-read/1-write register file with per-port replicated banks, registered
// reads, X/W bypass and a post-reset clear sequencer.
module urv_regfile_mp
   import urv_regfile_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int NREGS      = NREGS_DEF,
   parameter int NRD        = 2,
   parameter int ZERO_REG   = 1,
   parameter int INIT_CLEAR = 1
) (
   input logic            clk_i,
   input logic            rst_i,
   urv_regfile_mp_if.slave rf
);

   localparam int AW = clog2(NREGS);

   rf_state_e                state, state_nxt;
   logic [AW-1:0]            clr_cnt;
   logic                     run, we;
   logic                     mem_we;
   logic [AW-1:0]            mem_wa;
   logic [XLEN-1:0]          mem_wd;
   logic [NRD-1:0][XLEN-1:0] rdata, q, wb_val;
   logic [NRD-1:0][AW-1:0]   rf_rs_q;
   logic [NRD-1:0]           wb_hit, xb;

   assign run            = (state == RF_RUN);
   assign rf.init_busy_o = !run;

   // Pipeline writes only land in RUN; register 0 is read-only when hardwired.
   assign we = run && rf.w_rd_store_i && !((ZERO_REG != 0) && (rf.w_rd_i == '0));

   // During CLEAR the sweep owns the bank write port.
   assign mem_we = !run || we;
   assign mem_wa = run ? rf.w_rd_i : clr_cnt;
   assign mem_wd = run ? rf.w_rd_value_i : '0;

   // State register; reset always re-enters the clear sweep when enabled.
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= (INIT_CLEAR != 0) ? RF_CLEAR : RF_RUN;
      else       state <= state_nxt;
   end

   // Leave CLEAR after the last entry is zeroed; RUN is absorbing.
   always_comb begin
      state_nxt = state;
      if (state == RF_CLEAR && clr_cnt == AW'(NREGS - 1)) state_nxt = RF_RUN;
   end

   // Clear address counter, restarted by every reset.
   always_ff @(posedge clk_i) begin
      if (rst_i)                  clr_cnt <= '0;
      else if (state == RF_CLEAR) clr_cnt <= clr_cnt + AW'(1);
   end

   // One identical bank per read port.
   for (genvar k = 0; k < NRD; k++) begin : g_bank
      urv_regmem_1r1w #(.XLEN(XLEN), .NREGS(NREGS)) u_bank (
         .clk (clk_i),
         .we  (mem_we),
         .wa  (mem_wa),
         .wd  (mem_wd),
         .ra  (rf.rf_rs_i[k]),
         .rd  (rdata[k])
      );
   end

   // Registered read plus W-bypass capture. The array returns old data on a
   // same-cycle hit, so wb_hit/wb_val patch it; while stalled a write to the
   // latched address is captured so it is not lost when the stall releases.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q       <= '0;
         rf_rs_q <= '0;
         wb_hit  <= '0;
         wb_val  <= '0;
      end else begin
         for (int k = 0; k < NRD; k++) begin
            if (!rf.d_stall_i && run) begin
               q[k]       <= ((ZERO_REG != 0) && (rf.rf_rs_i[k] == '0)) ? '0 : rdata[k];
               rf_rs_q[k] <= rf.rf_rs_i[k];
            end
            if (!rf.d_stall_i) begin
               wb_hit[k] <= we && (rf.rf_rs_i[k] == rf.w_rd_i);
               if (we && (rf.rf_rs_i[k] == rf.w_rd_i)) wb_val[k] <= rf.w_rd_value_i;
            end else if (we && (rf.w_rd_i == rf_rs_q[k])) begin
               wb_hit[k] <= 1'b1;
               wb_val[k] <= rf.w_rd_value_i;
            end
         end
      end
   end

   // Operand mux: X-stage result first, then captured writeback, then array.
   always_comb begin
      xb              = '0;
      rf.x_rs_value_o = '0;
      for (int k = 0; k < NRD; k++) begin
         xb[k] = rf.w_bypass_rd_write_i && (rf.w_rd_i == rf.d_rs_i[k]) &&
                 !((ZERO_REG != 0) && (rf.w_rd_i == '0));
         if (xb[k])          rf.x_rs_value_o[k] = rf.w_bypass_rd_value_i;
         else if (wb_hit[k]) rf.x_rs_value_o[k] = wb_val[k];
         else                rf.x_rs_value_o[k] = q[k];
      end
   end

endmodule

// File: tb/tb_urv_regfile_mp.sv
// Self-checking bench: two instances (hardwired x0 and ordinary x0) driven
// in lockstep and compared each cycle against an architectural model.
module tb_urv_regfile_mp;
   import urv_regfile_pkg::*;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic                      stall = 1'b0;
   logic [NRD-1:0][AW-1:0]    rs    = '0;
   logic [NRD-1:0][AW-1:0]    drs   = '0;
   logic [AW-1:0]             wrd   = '0;
   logic [XLEN-1:0]           wval  = '0;
   logic                      wst   = 1'b0;
   logic                      bwr   = 1'b0;
   logic [XLEN-1:0]           bval  = '0;

   urv_regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) ifa ();
   urv_regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) ifb ();

   assign ifa.d_stall_i = stall;           assign ifb.d_stall_i = stall;
   assign ifa.rf_rs_i = rs;                assign ifb.rf_rs_i = rs;
   assign ifa.d_rs_i = drs;                assign ifb.d_rs_i = drs;
   assign ifa.w_rd_i = wrd;                assign ifb.w_rd_i = wrd;
   assign ifa.w_rd_value_i = wval;         assign ifb.w_rd_value_i = wval;
   assign ifa.w_rd_store_i = wst;          assign ifb.w_rd_store_i = wst;
   assign ifa.w_bypass_rd_write_i = bwr;   assign ifb.w_bypass_rd_write_i = bwr;
   assign ifa.w_bypass_rd_value_i = bval;  assign ifb.w_bypass_rd_value_i = bval;

   urv_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .INIT_CLEAR(1))
      dut_a (.clk_i(clk), .rst_i(rst), .rf(ifa));
   urv_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(0), .INIT_CLEAR(1))
      dut_b (.clk_i(clk), .rst_i(rst), .rf(ifb));

   int n_chk = 0;
   int n_err = 0;

   // Model: architectural register contents, the value each port is
   // presenting (value of its latched register, kept current by writes that
   // land while stalled), and cycles left in the clear sweep.
   logic [XLEN-1:0] mem  [2][NREGS];
   logic [XLEN-1:0] held [2][NRD];
   logic [AW-1:0]   lat  [2][NRD];
   int              clr_left = 0;

   task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [XLEN-1:0] arch(input int d, input logic [AW-1:0] a);
      return (d == 0 && a == 0) ? '0 : mem[d][a];
   endfunction

   task automatic model_edge();
      if (rst) begin
         clr_left = NREGS;
         for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < NREGS; r++) mem[d][r] = '0;
            for (int k = 0; k < NRD; k++) begin held[d][k] = '0; lat[d][k] = '0; end
         end
      end else begin
         bit running;
         running = (clr_left == 0);
         if (!running) clr_left--;
         for (int d = 0; d < 2; d++) begin
            bit wen;
            wen = running && wst && !(d == 0 && wrd == 0);
            if (wen) mem[d][wrd] = wval;
            for (int k = 0; k < NRD; k++) begin
               if (!stall && running) begin
                  lat[d][k]  = rs[k];
                  held[d][k] = arch(d, rs[k]);
               end else if (stall && wen && wrd == lat[d][k]) begin
                  held[d][k] = wval;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 2; d++) begin
         logic [XLEN-1:0] exp, got;
         got = (d == 0) ? XLEN'(ifa.init_busy_o) : XLEN'(ifb.init_busy_o);
         chk($sformatf("busy d%0d", d), got, XLEN'(clr_left > 0));
         for (int k = 0; k < NRD; k++) begin
            exp = (bwr && wrd == drs[k] && !(d == 0 && wrd == 0)) ? bval : held[d][k];
            got = (d == 0) ? ifa.x_rs_value_o[k] : ifb.x_rs_value_o[k];
            chk($sformatf("out d%0d p%0d", d, k), got, exp);
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle();
      rst = 0; stall = 0; wst = 0; bwr = 0; rs = '0; drs = '0; wrd = '0; wval = '0; bval = '0;
   endtask

   task automatic busy_run(input string tag, input int pre_cycles);
      int cnt;
      cnt = 0;
      idle(); rst = 1; cyc(); rst = 0;
      if (ifa.init_busy_o) cnt++;
      for (int i = 0; i < 40; i++) begin
         if (i == 3) begin wrd = 3; wval = 32'h1234; wst = 1; end
         cyc();
         wst = 0;
         if (ifa.init_busy_o) cnt++;
      end
      chk(tag, XLEN'(cnt), XLEN'(pre_cycles));
   endtask

   function automatic logic [AW-1:0] raddr();
      return ($urandom % 4 == 0) ? AW'($urandom_range(0, NREGS - 1)) : AW'($urandom_range(0, 3));
   endfunction

   initial begin
      int cnt;
      idle();
      #2;

      // Reset: 32 busy cycles, a write during the sweep is dropped.
      busy_run("busy_len", 32);
      for (int r = 0; r < NREGS; r++) begin
         rs[0] = AW'(r); rs[1] = AW'(NREGS - 1 - r);
         cyc();
         chk("clear_rd", ifb.x_rs_value_o[0], '0);
      end

      // Plain write then read on both ports.
      idle(); wrd = 5; wval = 32'hDEADBEEF; wst = 1; cyc();
      idle(); rs[0] = 5; rs[1] = 5; cyc();
      chk("rd_x5_p0", ifa.x_rs_value_o[0], 32'hDEADBEEF);
      chk("rd_x5_p1", ifa.x_rs_value_o[1], 32'hDEADBEEF);

      // Same-cycle W-bypass on port 0, X-bypass priority on port 1.
      idle(); wrd = 7; wval = 32'h11; wst = 1; rs[0] = 7; rs[1] = 7;
      drs[0] = 1; drs[1] = 7; bwr = 1; bval = 32'h22; cyc();
      chk("wbyp_p0", ifa.x_rs_value_o[0], 32'h11);
      chk("xbyp_p1", ifa.x_rs_value_o[1], 32'h22);

      // x0 write: hardwired instance ignores it and skips X-bypass on rd=0.
      idle(); wrd = 0; wval = 32'hFFFFFFFF; wst = 1; cyc();
      idle(); rs[0] = 0; rs[1] = 0; drs[0] = 0; drs[1] = 1; bwr = 1; bval = 32'h33; cyc();
      chk("x0_zr_p0", ifa.x_rs_value_o[0], '0);
      chk("x0_zr_p1", ifa.x_rs_value_o[1], '0);
      chk("x0_nz_xb", ifb.x_rs_value_o[0], 32'h33);
      chk("x0_nz_p1", ifb.x_rs_value_o[1], 32'hFFFFFFFF);

      // Stall coherence on a latched address.
      idle(); rs[0] = 9; drs = '1; cyc();
      stall = 1; rs[0] = 3; wrd = 9; wval = 32'hA5A5A5A5; wst = 1; cyc();
      chk("stall_wr", ifa.x_rs_value_o[0], 32'hA5A5A5A5);
      wst = 0; cyc();
      chk("stall_hold", ifa.x_rs_value_o[0], 32'hA5A5A5A5);
      stall = 0; rs[0] = 9; cyc();
      chk("stall_rel", ifa.x_rs_value_o[0], 32'hA5A5A5A5);

      // Reset mid-sweep at clr_cnt=10 restarts the full sweep.
      idle(); rst = 1; cyc(); rst = 0;
      for (int i = 0; i < 10; i++) cyc();
      rst = 1; cyc(); rst = 0;
      cnt = ifa.init_busy_o ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (ifa.init_busy_o) cnt++;
      end
      chk("busy_restart", XLEN'(cnt), 32'd32);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         rst   = ($urandom % 300 == 0);
         stall = ($urandom % 4 == 0);
         rs[0] = raddr(); rs[1] = raddr();
         drs[0] = raddr(); drs[1] = raddr();
         wrd   = raddr();
         wval  = $urandom;
         wst   = ($urandom % 2 == 0);
         bwr   = ($urandom % 4 == 0);
         bval  = $urandom;
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
